matrix_mem_seq: RTL

Memory-side sequencer that moves a 128-bit matrix register (four 32-bit lanes) between the pipeline and the 32-bit data memory. The execute stage produces the matrix operand and the store address, and this block serialises it into four word writes. For matrix loads it gathers four word reads back into one 128-bit result for writeback. It sits in the MEM stage beside the scalar load/store path and stalls the pipeline while a transfer is in flight.

---
 rtl/matrix_mem_seq_pkg.sv | 21 ++
 rtl/matrix_lane_mux.sv | 20 ++
 rtl/matrix_mem_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/matrix_mem_seq_pkg.sv
// Shared types and constants for the matrix memory sequencer.
// State encodings, matrix width and the lane address offset helper.
package matrix_mem_seq_pkg;

  localparam int unsigned MATRIX_W   = 128;
  localparam int unsigned LANE_SEL_W = 2;

  typedef enum logic [2:0] {
    MSEQ_IDLE  = 3'd0,
    MSEQ_STORE = 3'd1,
    MSEQ_LOAD  = 3'd2,
    MSEQ_LTAIL = 3'd3,
    MSEQ_DONE  = 3'd4
  } mseq_state_e;

  // Byte offset of a lane relative to the matrix base address.
  function automatic logic [31:0] lane_offset(input logic [LANE_SEL_W-1:0] beat);
    return {28'b0, beat, 2'b00};
  endfunction

endpackage

// File: rtl/matrix_lane_mux.sv
// Selects one 32-bit lane of the latched matrix for store data.
module matrix_lane_mux
  import matrix_mem_seq_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic [BEATS*WORD_W-1:0] matrix,
  input  logic [LANE_SEL_W-1:0]   sel,
  output logic [WORD_W-1:0]       lane
);

  always_comb begin
    lane = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (sel == i[LANE_SEL_W-1:0]) lane = matrix[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/matrix_mem_seq.sv
// MEM-stage sequencer: serialises a 128-bit matrix into four word writes,
// or gathers four word reads into a 128-bit load result.
module matrix_mem_seq
  import matrix_mem_seq_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                st_req,
  input  logic                ld_req,
  input  logic [WORD_W-1:0]   base_addr,
  input  logic [MATRIX_W-1:0] st_matrix,
  output logic [WORD_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic [MATRIX_W-1:0] ld_matrix,
  output logic                done,
  output logic                err,
  output logic                stall
);

  mseq_state_e           state, next_state;
  logic [LANE_SEL_W-1:0] beat;
  logic [WORD_W-1:0]     base_q;
  logic [MATRIX_W-1:0]   matrix_q;
  logic [WORD_W-1:0]     lane_data;
  logic [WORD_W-1:0]     beat_addr;
  logic                  req, aligned, accept, err_d, cap_en;
  logic [LANE_SEL_W-1:0] cap_lane;

  assign req       = st_req | ld_req;
  assign aligned   = (base_addr[1:0] == 2'b00);
  assign beat_addr = base_q + lane_offset(beat);

  matrix_lane_mux #(
    .BEATS  (BEATS),
    .WORD_W (WORD_W)
  ) u_lane_mux (
    .matrix (matrix_q),
    .sel    (beat),
    .lane   (lane_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= MSEQ_IDLE;
    else       state <= next_state;
  end

  // Memory strobes depend only on registered state; stall also sees the request.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done       = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    err_d      = 1'b0;
    cap_en     = 1'b0;
    cap_lane   = '0;
    case (state)
      MSEQ_IDLE: begin
        if (req) begin
          err_d = !aligned || (st_req && ld_req);
          if (aligned) begin
            accept     = 1'b1;
            stall      = 1'b1;
            next_state = st_req ? MSEQ_STORE : MSEQ_LOAD;
          end
        end
      end
      MSEQ_STORE: begin
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = lane_data;
        stall     = 1'b1;
        if (beat == 2'd3) next_state = MSEQ_DONE;
      end
      MSEQ_LOAD: begin
        mem_re   = 1'b1;
        mem_addr = beat_addr;
        stall    = 1'b1;
        cap_en   = (beat != 2'd0);
        cap_lane = beat - 2'd1;
        if (beat == 2'd3) next_state = MSEQ_LTAIL;
      end
      MSEQ_LTAIL: begin
        stall      = 1'b1;
        cap_en     = 1'b1;
        cap_lane   = 2'd3;
        next_state = MSEQ_DONE;
      end
      MSEQ_DONE: begin
        done       = 1'b1;
        next_state = MSEQ_IDLE;
      end
      default: next_state = MSEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat      <= '0;
      base_q    <= '0;
      matrix_q  <= '0;
      ld_matrix <= '0;
      err       <= 1'b0;
    end else begin
      err <= err_d;
      if (accept) begin
        base_q   <= base_addr;
        matrix_q <= st_matrix;
        beat     <= '0;
      end else if (state == MSEQ_STORE || state == MSEQ_LOAD) begin
        beat <= beat + 2'd1;
      end
      // Read data trails the strobe by one cycle, so lanes fill one beat behind.
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cap_en && cap_lane == i[LANE_SEL_W-1:0])
          ld_matrix[i*WORD_W +: WORD_W] <= mem_rdata;
      end
    end
  end

endmodule
